// File: rtl/bc_replay_buffer.sv
// Ping-pong broadcast buffer: stores NrLanes*ELEN load beats per bank and replays each vector ELEN-wide, lockstep to all targets.
// Read data is valid one cycle after the last beat; writes stall only while every bank holds a full vector, reads stall until all enabled targets are ready.
module bc_replay_buffer #(
   parameter int unsigned NrLanes   = 4,
   parameter int unsigned ELEN      = 64,
   parameter int unsigned Depth     = 64,
   parameter int unsigned NrBanks   = 2,
   parameter int unsigned NrTargets = 1,
   parameter int unsigned ReplayW   = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NrLanes*ELEN-1:0] wr_data_i,
   input  logic                    wr_valid_i,
   input  logic                    wr_last_i,
   output logic                    wr_ready_o,
   input  logic [ReplayW-1:0]      cfg_replay_i,
   output logic [ELEN-1:0]         rd_data_o,
   output logic                    rd_valid_o,
   output logic                    rd_last_o,
   input  logic [NrTargets-1:0]    rd_target_en_i,
   input  logic [NrTargets-1:0]    rd_ready_i,
   input  logic                    invalidate_i,
   output logic [NrBanks-1:0]      bank_busy_o
);

   localparam int unsigned Words = Depth / NrLanes;
   localparam int unsigned WptrW = $clog2(Words);
   localparam int unsigned LaneW = $clog2(NrLanes);
   localparam int unsigned EW    = $clog2(Depth);
   localparam int unsigned LenW  = $clog2(Depth + 1);
   localparam int unsigned BankW = $clog2(NrBanks);
   localparam logic [ReplayW:0] PassOne = (ReplayW + 1)'(1);
   localparam logic [WptrW:0]   WordOne = (WptrW + 1)'(1);

   typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_e;

   bank_state_e             state_q  [NrBanks];
   bank_state_e             state_d  [NrBanks];
   logic [LenW-1:0]         len_q    [NrBanks];
   logic [LenW-1:0]         len_d    [NrBanks];
   logic [ReplayW-1:0]      replay_q [NrBanks];
   logic [ReplayW-1:0]      replay_d [NrBanks];
   logic [NrLanes*ELEN-1:0] mem_q    [NrBanks][Words];

   logic [WptrW-1:0]        wptr_q, wptr_d;
   logic [BankW-1:0]        wr_bank_q, wr_bank_d;
   logic [BankW-1:0]        rd_bank_q, rd_bank_d;
   logic [EW-1:0]           e_q, e_d;
   logic [ReplayW-1:0]      pass_q, pass_d;
   logic                    wr_fire, wr_is_last, rd_fire, final_pass;
   logic [NrLanes*ELEN-1:0] rd_word;

   assign wr_ready_o = (state_q[wr_bank_q] != BANK_FULL);
   assign wr_fire    = wr_valid_i && wr_ready_o;
   // The last word of a bank closes the vector even without wr_last_i.
   assign wr_is_last = wr_last_i || (wptr_q == WptrW'(Words - 1));

   assign rd_valid_o = (state_q[rd_bank_q] == BANK_FULL);
   assign rd_fire    = rd_valid_o && (&(rd_ready_i | ~rd_target_en_i));
   assign rd_last_o  = rd_valid_o && (LenW'(e_q) == len_q[rd_bank_q] - LenW'(1));
   assign final_pass = rd_fire && rd_last_o &&
                       (({1'b0, pass_q} + PassOne) == {1'b0, replay_q[rd_bank_q]});

   assign rd_word   = mem_q[rd_bank_q][e_q[EW-1:LaneW]];
   assign rd_data_o = rd_valid_o ? rd_word[e_q[LaneW-1:0]*ELEN +: ELEN] : '0;

   for (genvar b = 0; b < NrBanks; b++) begin : g_busy
      assign bank_busy_o[b] = (state_q[b] != BANK_EMPTY);
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      replay_d  = replay_q;
      wptr_d    = wptr_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      e_d       = e_q;
      pass_d    = pass_q;

      if (wr_fire) begin
         if (wr_is_last) begin
            state_d[wr_bank_q]  = BANK_FULL;
            len_d[wr_bank_q]    = LenW'({1'b0, wptr_q} + WordOne) << LaneW;
            replay_d[wr_bank_q] = (cfg_replay_i == '0) ? ReplayW'(1) : cfg_replay_i;
            wptr_d              = '0;
            wr_bank_d           = wr_bank_q + BankW'(1);
         end else begin
            state_d[wr_bank_q] = BANK_FILLING;
            wptr_d             = wptr_q + WptrW'(1);
         end
      end

      if (rd_fire) begin
         if (rd_last_o) begin
            e_d = '0;
            if (final_pass) begin
               state_d[rd_bank_q] = BANK_EMPTY;
               pass_d             = '0;
               rd_bank_d          = rd_bank_q + BankW'(1);
            end else begin
               pass_d = pass_q + ReplayW'(1);
            end
         end else begin
            e_d = e_q + EW'(1);
         end
      end

      // Invalidate wins over a same-cycle write or final transfer; both pointers move at most once.
      if (invalidate_i && (state_q[rd_bank_q] != BANK_EMPTY)) begin
         state_d[rd_bank_q] = BANK_EMPTY;
         e_d                = '0;
         pass_d             = '0;
         rd_bank_d          = rd_bank_q + BankW'(1);
         if (state_q[rd_bank_q] == BANK_FILLING) begin
            wptr_d    = '0;
            wr_bank_d = wr_bank_q + BankW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int b = 0; b < NrBanks; b++) begin
            state_q[b]  <= BANK_EMPTY;
            len_q[b]    <= '0;
            replay_q[b] <= '0;
         end
         wptr_q    <= '0;
         wr_bank_q <= '0;
         rd_bank_q <= '0;
         e_q       <= '0;
         pass_q    <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         replay_q  <= replay_d;
         wptr_q    <= wptr_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         e_q       <= e_d;
         pass_q    <= pass_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && wr_fire) begin
         mem_q[wr_bank_q][wptr_q] <= wr_data_i;
      end
   end

endmodule

// File: tb/tb_bc_replay_buffer.sv
// Directed bench for bc_replay_buffer: reset, single pass, stalled replay, ping-pong, invalidate, overflow, mid-run reset.
module tb_bc_replay_buffer;

   localparam int NrLanes   = 4;
   localparam int ELEN      = 64;
   localparam int Depth     = 64;
   localparam int NrBanks   = 2;
   localparam int NrTargets = 2;
   localparam int ReplayW   = 4;

   logic                    clk_i = 1'b0;
   logic                    rst_i;
   logic [NrLanes*ELEN-1:0] wr_data_i;
   logic                    wr_valid_i;
   logic                    wr_last_i;
   logic                    wr_ready_o;
   logic [ReplayW-1:0]      cfg_replay_i;
   logic [ELEN-1:0]         rd_data_o;
   logic                    rd_valid_o;
   logic                    rd_last_o;
   logic [NrTargets-1:0]    rd_target_en_i;
   logic [NrTargets-1:0]    rd_ready_i;
   logic                    invalidate_i;
   logic [NrBanks-1:0]      bank_busy_o;

   int checks = 0;
   int errors = 0;

   bc_replay_buffer #(
      .NrLanes(NrLanes), .ELEN(ELEN), .Depth(Depth),
      .NrBanks(NrBanks), .NrTargets(NrTargets), .ReplayW(ReplayW)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_last_i(wr_last_i),
      .wr_ready_o(wr_ready_o), .cfg_replay_i(cfg_replay_i),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_last_o(rd_last_o),
      .rd_target_en_i(rd_target_en_i), .rd_ready_i(rd_ready_i),
      .invalidate_i(invalidate_i), .bank_busy_o(bank_busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [NrLanes*ELEN-1:0] beat(input logic [63:0] base);
      logic [NrLanes*ELEN-1:0] r;
      for (int l = 0; l < NrLanes; l++) r[l*ELEN +: ELEN] = base + 64'(l);
      return r;
   endfunction

   task automatic write_vec(input logic [63:0] base, input int nbeats,
                            input logic [ReplayW-1:0] cfg, input logic mark_last);
      for (int b = 0; b < nbeats; b++) begin
         wr_valid_i   = 1'b1;
         wr_data_i    = beat(base + 64'(b * NrLanes));
         wr_last_i    = mark_last && (b == nbeats - 1);
         cfg_replay_i = cfg;
         #1;
         check("wr_ready", wr_ready_o, 1'b1);
         cyc();
      end
      wr_valid_i = 1'b0;
      wr_last_i  = 1'b0;
   endtask

   task automatic read_vec(input logic [63:0] base, input int len);
      for (int i = 0; i < len; i++) begin
         #1;
         check("rd_valid", rd_valid_o, 1'b1);
         check("rd_data", rd_data_o, base + 64'(i));
         check("rd_last", rd_last_o, (i == len - 1));
         cyc();
      end
   endtask

   initial begin
      logic [63:0] exp_q[$];
      int n, lastcnt, ws, stall, bacc, cacc, nrd;

      rst_i = 1'b1; wr_valid_i = 1'b0; wr_last_i = 1'b0; wr_data_i = '0;
      cfg_replay_i = 4'd1; rd_target_en_i = 2'b11; rd_ready_i = 2'b11; invalidate_i = 1'b0;

      // Reset values
      cyc(); cyc();
      check("rst_wr_ready", wr_ready_o, 1'b1);
      check("rst_rd_valid", rd_valid_o, 1'b0);
      check("rst_rd_last", rd_last_o, 1'b0);
      check("rst_busy", bank_busy_o, 2'b00);
      check("rst_rd_data", rd_data_o, 64'd0);
      rst_i = 1'b0;
      cyc();

      // Single pass, two beats, bank 0
      write_vec(64'd0, 1, 4'd1, 1'b0);
      check("fill_no_read", rd_valid_o, 1'b0);
      check("fill_busy", bank_busy_o, 2'b01);
      write_vec(64'd4, 1, 4'd1, 1'b1);
      check("single_busy", bank_busy_o, 2'b01);
      read_vec(64'd0, 8);
      check("single_freed_valid", rd_valid_o, 1'b0);
      check("single_freed_busy", bank_busy_o, 2'b00);

      // Replay x3 with target 1 stalling on alternate cycles, bank 1
      write_vec(64'h100, 1, 4'd3, 1'b1);
      n = 0; lastcnt = 0;
      for (int cc = 0; cc < 40 && n < 12; cc++) begin
         rd_ready_i = {cc[0], 1'b1};
         #1;
         check("stall_valid", rd_valid_o, 1'b1);
         check("stall_data", rd_data_o, 64'h100 + 64'(n % 4));
         check("stall_last", rd_last_o, (n % 4 == 3));
         if (rd_valid_o && rd_ready_i == 2'b11) begin
            if (rd_last_o) lastcnt++;
            n++;
         end
         cyc();
      end
      rd_ready_i = 2'b11;
      check("stall_transfers", 64'(n), 64'd12);
      check("stall_lasts", 64'(lastcnt), 64'd3);
      check("stall_freed", rd_valid_o, 1'b0);

      // Ping-pong: A (replay 4) in bank 0, B written during A, C stalls until A frees
      rd_target_en_i = 2'b01; rd_ready_i = 2'b01;
      write_vec(64'h200, 1, 4'd4, 1'b1);
      for (int p = 0; p < 4; p++) for (int k = 0; k < 4; k++) exp_q.push_back(64'h200 + 64'(k));
      for (int k = 0; k < 4; k++) exp_q.push_back(64'h300 + 64'(k));
      for (int k = 0; k < 4; k++) exp_q.push_back(64'h400 + 64'(k));
      ws = 0; stall = 0; bacc = -1; cacc = -1; nrd = 0;
      for (int cc = 0; cc < 60 && (exp_q.size() > 0 || ws < 2); cc++) begin
         wr_valid_i   = (ws < 2);
         wr_data_i    = beat((ws == 0) ? 64'h300 : 64'h400);
         wr_last_i    = 1'b1;
         cfg_replay_i = 4'd1;
         #1;
         if (wr_valid_i) begin
            if (wr_ready_o) begin
               if (ws == 0) bacc = cc; else cacc = cc;
               ws++;
            end else stall++;
         end
         if (rd_valid_o && exp_q.size() > 0) begin
            check("pp_data", rd_data_o, exp_q[0]);
            check("pp_last", rd_last_o, (nrd % 4 == 3));
            void'(exp_q.pop_front());
            nrd++;
         end
         cyc();
      end
      wr_valid_i = 1'b0; wr_last_i = 1'b0;
      rd_target_en_i = 2'b11; rd_ready_i = 2'b11;
      check("pp_b_no_stall", 64'(bacc), 64'd0);
      check("pp_c_accept", 64'(cacc), 64'd16);
      check("pp_c_stall", 64'(stall), 64'd15);
      check("pp_drained", 64'(exp_q.size()), 64'd0);
      #1;
      check("pp_idle", rd_valid_o, 1'b0);

      // Invalidate during pass 2 of D (bank 1); E waits in bank 0
      write_vec(64'h500, 1, 4'd3, 1'b1);
      wr_valid_i = 1'b1; wr_data_i = beat(64'h600); wr_last_i = 1'b1; cfg_replay_i = 4'd1;
      #1;
      check("inv_e_accept", wr_ready_o, 1'b1);
      check("inv_d0", rd_data_o, 64'h500);
      cyc();
      wr_valid_i = 1'b0; wr_last_i = 1'b0;
      for (int i = 1; i < 6; i++) begin
         #1;
         check("inv_d_data", rd_data_o, 64'h500 + 64'(i % 4));
         cyc();
      end
      rd_ready_i = 2'b00; invalidate_i = 1'b1;
      #1;
      check("inv_pre_valid", rd_valid_o, 1'b1);
      check("inv_pre_data", rd_data_o, 64'h502);
      cyc();
      invalidate_i = 1'b0; rd_ready_i = 2'b11;
      #1;
      check("inv_moved_data", rd_data_o, 64'h600);
      check("inv_moved_busy", bank_busy_o, 2'b01);
      read_vec(64'h600, 4);
      check("inv_done_busy", bank_busy_o, 2'b00);

      // Invalidate on an empty read bank changes nothing
      invalidate_i = 1'b1;
      cyc();
      invalidate_i = 1'b0;
      #1;
      check("inv_empty_busy", bank_busy_o, 2'b00);
      check("inv_empty_ready", wr_ready_o, 1'b1);
      write_vec(64'h700, 1, 4'd1, 1'b1);
      check("inv_empty_valid", rd_valid_o, 1'b1);
      check("inv_empty_bank", bank_busy_o, 2'b10);
      read_vec(64'h700, 4);

      // Invalidate a filling bank: partial fill dropped, both pointers advance
      write_vec(64'h900, 1, 4'd1, 1'b0);
      check("invf_busy", bank_busy_o, 2'b01);
      check("invf_no_read", rd_valid_o, 1'b0);
      invalidate_i = 1'b1;
      cyc();
      invalidate_i = 1'b0;
      #1;
      check("invf_cleared", bank_busy_o, 2'b00);
      write_vec(64'hA00, 1, 4'd1, 1'b1);
      check("invf_next_bank", bank_busy_o, 2'b10);
      read_vec(64'hA00, 4);

      // Overflow: 16 beats without last, replay 0 means one pass
      write_vec(64'h800, Depth / NrLanes, 4'd0, 1'b0);
      check("ovf_busy", bank_busy_o, 2'b01);
      read_vec(64'h800, Depth);
      #1;
      check("ovf_one_pass", rd_valid_o, 1'b0);
      check("ovf_freed", bank_busy_o, 2'b00);

      // Reset mid-operation
      write_vec(64'hB00, 1, 4'd2, 1'b1);
      check("mid_valid", rd_valid_o, 1'b1);
      rst_i = 1'b1;
      cyc();
      check("mid_rst_valid", rd_valid_o, 1'b0);
      check("mid_rst_busy", bank_busy_o, 2'b00);
      check("mid_rst_data", rd_data_o, 64'd0);
      rst_i = 1'b0;
      cyc();
      write_vec(64'hC00, 1, 4'd1, 1'b1);
      check("post_rst_bank", bank_busy_o, 2'b01);
      read_vec(64'hC00, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: observed no end expected end");
      $fatal(1, "timeout");
   end

endmodule
